// File: rtl/spi_frame_rx_fifo.sv
// SPI frame receiver, oversampled in the clk domain: deserialises
// [VALUE][ROW][COL][FLAGS] frames MSB-first into a small valid/ready FIFO.

module spi_frame_rx_sync #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic [1:0] sync_pipe;

   always_ff @(posedge clk) begin
      if (rst) sync_pipe <= {2{RST_VAL}};
      else     sync_pipe <= {sync_pipe[0], d};
   end

   assign q = sync_pipe[1];
endmodule

module spi_frame_rx_fifo #(
   parameter int DATA_W      = 32,
   parameter int IDX_W       = 16,
   parameter int FIFO_DEPTH  = 4,
   parameter int SAMPLE_FALL = 0,
   parameter int CNT_W       = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          spi_clk,
   input  logic                          spi_cs_n,
   input  logic                          spi_mosi,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_W-1:0]             out_val,
   output logic [IDX_W-1:0]              out_row,
   output logic [IDX_W-1:0]              out_col,
   output logic [7:0]                    out_flags,
   output logic                          out_last,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [CNT_W-1:0]              overflow_cnt,
   output logic [CNT_W-1:0]              abort_cnt,
   output logic                          busy
);
   localparam int FRAME_BITS = DATA_W + 2*IDX_W + 8;
   localparam int BC_W       = $clog2(FRAME_BITS);
   localparam int AW         = $clog2(FIFO_DEPTH);
   localparam int LW         = AW + 1;

   typedef struct packed {
      logic [DATA_W-1:0] val;
      logic [IDX_W-1:0]  row;
      logic [IDX_W-1:0]  col;
      logic [7:0]        flags;
   } frame_t;

   // Pins share one identical chain so clk/cs/data stay cycle-aligned.
   // Bit order: [2]=spi_clk, [1]=cs_n, [0]=mosi.
   localparam logic [2:0] SYNC_RST = 3'b010;

   logic [2:0] pin_raw;
   logic [2:0] pin_s;

   assign pin_raw = {spi_clk, spi_cs_n, spi_mosi};

   for (genvar g = 0; g < 3; g++) begin : g_sync
      spi_frame_rx_sync #(.RST_VAL(SYNC_RST[g])) u_sync (
         .clk (clk),
         .rst (rst),
         .d   (pin_raw[g]),
         .q   (pin_s[g])
      );
   end

   logic sclk_s, cs_n_s, mosi_s;
   logic sclk_d, cs_n_d;

   assign sclk_s = pin_s[2];
   assign cs_n_s = pin_s[1];
   assign mosi_s = pin_s[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_d <= 1'b0;
         cs_n_d <= 1'b1;
      end else begin
         sclk_d <= sclk_s;
         cs_n_d <= cs_n_s;
      end
   end

   logic                  sclk_edge, sample_pulse, frame_done, cs_rise, abort;
   logic [BC_W-1:0]       bit_cnt;
   logic [FRAME_BITS-2:0] shift_reg;
   logic [FRAME_BITS-1:0] frame_word;

   assign sclk_edge    = (SAMPLE_FALL != 0) ? (sclk_d & ~sclk_s) : (~sclk_d & sclk_s);
   assign sample_pulse = sclk_edge & ~cs_n_s;
   assign frame_done   = sample_pulse && (bit_cnt == BC_W'(FRAME_BITS-1));
   assign frame_word   = {shift_reg, mosi_s};
   assign cs_rise      = cs_n_s & ~cs_n_d;
   assign abort        = cs_rise && (bit_cnt != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         shift_reg <= '0;
         bit_cnt   <= '0;
         abort_cnt <= '0;
      end else begin
         if (cs_n_s) begin
            bit_cnt <= '0;
         end else if (sample_pulse) begin
            shift_reg <= frame_word[FRAME_BITS-2:0];
            bit_cnt   <= frame_done ? '0 : bit_cnt + BC_W'(1);
         end
         if (abort && (abort_cnt != '1)) abort_cnt <= abort_cnt + CNT_W'(1);
      end
   end

   assign busy = ~cs_n_s & (bit_cnt != '0);

   // Frame FIFO. When full, a same-cycle pop frees the slot the push lands in.
   frame_t          mem [FIFO_DEPTH];
   frame_t          head;
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [LW-1:0]   level;
   logic            full, pop, push_ok, drop;

   assign full    = (level == LW'(FIFO_DEPTH));
   assign pop     = out_valid & out_ready;
   assign push_ok = frame_done & (~full | pop);
   assign drop    = frame_done & full & ~pop;

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= frame_t'(frame_word);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         level        <= '0;
         overflow_cnt <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
         if (drop && (overflow_cnt != '1)) overflow_cnt <= overflow_cnt + CNT_W'(1);
      end
   end

   // Memory is not reset, so the head is masked to zero while empty.
   assign out_valid  = (level != '0);
   assign head       = out_valid ? mem[rd_ptr] : '0;
   assign out_val    = head.val;
   assign out_row    = head.row;
   assign out_col    = head.col;
   assign out_flags  = head.flags;
   assign out_last   = head.flags[0];
   assign fifo_level = level;
endmodule
